// File: rtl/alu8_mul_seq.sv
// alu8_mul_seq: 8x8 unsigned shift-and-add multiplier sequencer.
// It computes nothing itself. It drives the external alu8 one operation per
// cycle and registers the result. The ADD and SHIFT states alternate eight
// times each, so the latency is always 16 cycles.
//
// Handshake: START is a request. It is accepted on a rising edge only while
// the sequencer is idle (IDLE or DONE state). BUSY is high while a multiply
// is in flight, and START is ignored then. DONE is a one-cycle pulse that
// marks PROD as valid. PROD then holds until the next accepted START.
module alu8_mul_seq #(
  parameter logic [5:0] OP_ADD        = 6'b001001,
  parameter logic [5:0] OP_ROR        = 6'b100000,
  parameter logic       CARRY_ACT_LOW = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  MCAND,
  input  logic [7:0]  MPLIER,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] PROD,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic        ALU_CI,
  output logic [5:0]  ALU_OP,
  input  logic [7:0]  ALU_F,
  input  logic        ALU_CO,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // "No carry" as the ALU's add path sees it.
  localparam logic NO_CARRY = CARRY_ACT_LOW;

  state_t      state;
  state_t      state_next;
  logic [7:0]  md;
  logic [7:0]  p;
  logic [7:0]  mq;
  logic        c;
  logic [2:0]  cnt;

  assign PROD      = {p, mq};
  assign dbg_state = state;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and the Moore outputs that drive the ALU.
  always_comb begin
    state_next = state;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ALU_OP     = OP_ADD;
    ALU_A      = 8'h00;
    ALU_B      = 8'h00;
    ALU_CI     = NO_CARRY;
    case (state)
      S_IDLE: begin
        if (START) state_next = S_ADD;
      end
      S_ADD: begin
        BUSY       = 1'b1;
        ALU_A      = p;
        ALU_B      = md;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        BUSY       = 1'b1;
        ALU_OP     = OP_ROR;
        ALU_A      = p;
        ALU_B      = md;
        ALU_CI     = c;
        state_next = (cnt == 3'd7) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        DONE       = 1'b1;
        state_next = START ? S_ADD : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers.
  // In ADD the sum is kept only when the current multiplier bit is set.
  // Either way ADD takes one cycle, so the timing does not depend on the data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      md  <= 8'h00;
      p   <= 8'h00;
      mq  <= 8'h00;
      c   <= 1'b0;
      cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            md  <= MCAND;
            mq  <= MPLIER;
            p   <= 8'h00;
            c   <= 1'b0;
            cnt <= 3'd0;
          end
        end
        S_ADD: begin
          if (mq[0]) begin
            p <= ALU_F;
            c <= ALU_CO ^ CARRY_ACT_LOW;
          end else begin
            c <= 1'b0;
          end
        end
        S_SHIFT: begin
          // The bit rotated out of P becomes the next low-product bit.
          p  <= ALU_F;
          mq <= {ALU_CO, mq[7:1]};
          c  <= 1'b0;
          if (cnt != 3'd7) cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu8_mul_seq.sv
// Bench for alu8_mul_seq. A behavioural alu8 (add and rotate only) is
// attached to the ALU ports. A reference model predicts BUSY, DONE, PROD and
// the ALU control on every cycle. Directed multiplies pin the model with
// hand-computed products and latencies.
module tb_alu8_mul_seq;

  localparam logic [5:0] OP_ADD        = 6'b001001;
  localparam logic [5:0] OP_ROR        = 6'b100000;
  localparam logic       CARRY_ACT_LOW = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] prod;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_ci;
  logic [5:0]  alu_op;
  logic [7:0]  alu_f;
  logic        alu_co;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  alu8_mul_seq #(
    .OP_ADD(OP_ADD), .OP_ROR(OP_ROR), .CARRY_ACT_LOW(CARRY_ACT_LOW)
  ) dut (
    .CLK(clk), .RESET(reset), .START(start), .MCAND(mcand), .MPLIER(mplier),
    .BUSY(busy), .DONE(done), .PROD(prod),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_CI(alu_ci), .ALU_OP(alu_op),
    .ALU_F(alu_f), .ALU_CO(alu_co), .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural alu8 subset.
  logic [8:0] sum;
  always_comb begin
    sum    = 9'd0;
    alu_f  = 8'h00;
    alu_co = 1'b0;
    if (alu_op == OP_ADD) begin
      sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci ^ CARRY_ACT_LOW};
      alu_f  = sum[7:0];
      alu_co = sum[8] ^ CARRY_ACT_LOW;
    end else if (alu_op == OP_ROR) begin
      alu_f  = {alu_ci, alu_a[7:1]};
      alu_co = alu_a[0];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a started multiply occupies 16 cycles. It then
  // presents a*b with a DONE pulse.
  logic [15:0] exp_q[$];
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_prod = 16'h0000;

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= 16'h0000;
      exp_q.delete();
    end else if (m_left == 0 && start) begin
      exp_q.push_back(16'(mcand) * 16'(mplier));
      m_left <= 16;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_prod <= exp_q.pop_front();
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", int'(busy), int'(m_left > 0));
      check("done", int'(done), int'(m_done));
      if (m_left == 0) begin
        check("prod", int'(prod), int'(m_prod));
        check("idle_op", int'(alu_op), int'(OP_ADD));
        check("idle_a", int'(alu_a), 0);
        check("idle_b", int'(alu_b), 0);
        check("idle_ci", int'(alu_ci), int'(CARRY_ACT_LOW));
      end else begin
        // The first busy cycle (16 left) is an ADD; then the ops alternate.
        check("busy_op", int'(alu_op), int'(((m_left % 2) == 0) ? OP_ADD : OP_ROR));
      end
    end
  end

  // Driver tasks. Inputs change on the falling edge.
  task automatic start_mul(input logic [7:0] a, input logic [7:0] b);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(negedge clk);
    start  = 1'b0;
    mcand  = 8'h00;
    mplier = 8'h00;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      $display("FAIL wait_done: no DONE within 40 cycles");
    end
  endtask

  task automatic mul_check(input string name, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp);
    int n;
    start_mul(a, b);
    wait_done(n);
    check({name, "_lat"}, n, 16);
    check({name, "_prod"}, int'(prod), int'(exp));
    @(negedge clk);
  endtask

  initial begin
    int n;
    int n2;
    int dcount;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = 8'h00;
    mplier = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_prod", int'(prod), 0);
    check("rst_op", int'(alu_op), int'(OP_ADD));

    mul_check("m0d0b", 8'h0D, 8'h0B, 16'h008F);
    mul_check("mffff", 8'hFF, 8'hFF, 16'hFE01);
    mul_check("m00ff", 8'h00, 8'hFF, 16'h0000);

    // Back-to-back: START in the DONE cycle of 0x80 x 0x02.
    start_mul(8'h80, 8'h02);
    wait_done(n);
    check("m8002_lat", n, 16);
    check("m8002_prod", int'(prod), 16'h0100);
    start_mul(8'h12, 8'h34);
    check("b2b_busy", int'(busy), 1);
    wait_done(n);
    check("b2b_lat", n + 1, 17);
    check("b2b_prod", int'(prod), 16'h03A8);
    @(negedge clk);

    // START while busy is ignored.
    start_mul(8'h0D, 8'h0B);
    repeat (4) @(negedge clk);
    start_mul(8'h01, 8'h01);
    wait_done(n2);
    check("ign_lat", 5 + n2, 16);
    check("ign_prod", int'(prod), 16'h008F);
    @(negedge clk);

    // Reset mid-multiply.
    start_mul(8'h0D, 8'h0B);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", int'(busy), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_prod", int'(prod), 0);
    check("mrst_op", int'(alu_op), int'(OP_ADD));
    check("mrst_a", int'(alu_a), 0);
    check("mrst_b", int'(alu_b), 0);
    dcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mrst_nodone", dcount, 0);
    mul_check("m0305", 8'h03, 8'h05, 16'h000F);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
